// File: rtl/divider.sv
// Multi-cycle unsigned restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// One quotient bit per clock, with a start/done handshake and the 8086 divide-error check.
module divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   Dividend,
  input  logic [WIDTH-1:0]     Divisor,
  output logic [WIDTH-1:0]     Quotient,
  output logic [WIDTH-1:0]     Remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 div_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;
  localparam int         CW      = $clog2(WIDTH + 1);

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             error_reg;

  logic [WIDTH:0]   r_shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             overflow;
  logic             last_step;

  // After every restoring step R < Divisor, so its top bit is always zero and
  // the shifted partial remainder fits in W+1 bits. The extra bit of the trial
  // difference acts as the borrow.
  assign r_shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign trial     = {1'b0, r_shifted} - {2'b00, divisor_reg};
  assign trial_ok  = ~trial[WIDTH+1];
  assign r_next    = trial_ok ? trial[WIDTH:0] : r_shifted;
  assign q_next    = (q_reg << 1) | WIDTH'(trial_ok);

  // Upper half >= divisor means the quotient cannot fit in W bits (also catches /0).
  assign overflow  = (Dividend[2*WIDTH-1:WIDTH] >= Divisor);
  assign last_step = (count_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            divisor_reg <= Divisor;
            if (overflow) begin
              error_reg <= 1'b1;
              done_reg  <= 1'b1;
              state_reg <= DONE_ST;
            end else begin
              error_reg <= 1'b0;
              r_reg     <= {1'b0, Dividend[2*WIDTH-1:WIDTH]};
              q_reg     <= Dividend[WIDTH-1:0];
              count_reg <= '0;
              busy_reg  <= 1'b1;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          r_reg     <= r_next;
          q_reg     <= q_next;
          count_reg <= count_reg + 1'b1;
          if (last_step) begin
            quotient_reg  <= q_next;
            remainder_reg <= r_next[WIDTH-1:0];
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE_ST;
          end
        end
        DONE_ST: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign Quotient  = quotient_reg;
  assign Remainder = remainder_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign div_error = error_reg;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: the driver pushes expected results computed with plain / and %,
// and a monitor pops and compares them whenever done is seen.
module tb_divider;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*W-1:0] Dividend;
  logic [W-1:0]   Divisor;
  logic [W-1:0]   Quotient;
  logic [W-1:0]   Remainder;
  logic           busy;
  logic           done;
  logic           div_error;

  divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Quotient(Quotient), .Remainder(Remainder),
    .busy(busy), .done(done), .div_error(div_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
    int           done_cyc;
    int           busy_cycles;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  int           busy_run = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (busy && done) begin
        miscompares++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b, expected not both (cycle %0d)", busy, done, cyc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: done=1 with no operation pending (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, ".quotient"},  Quotient,  e.q);
          check({e.tag, ".remainder"}, Remainder, e.r);
          check({e.tag, ".div_error"}, div_error, e.err);
          check({e.tag, ".latency"},   cyc,       e.done_cyc);
          check({e.tag, ".busy_cyc"},  busy_run,  e.busy_cycles);
          $display("op %s: Q=%0d R=%0d err=%0b at cycle %0d", e.tag, Quotient, Remainder, div_error, cyc);
        end
        busy_run = 0;
      end
    end
  end

  // Reference: DIV r/m8 semantics, written directly as arithmetic.
  task automatic issue(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input string tag);
    exp_t e;
    int   hi;
    @(negedge clk);
    Dividend = dd;
    Divisor  = dv;
    start    = 1'b1;
    hi       = int'(dd) / 256;
    e.tag    = tag;
    e.err    = (dv == 0) || (hi >= int'(dv));
    if (e.err) begin
      e.q = last_q;
      e.r = last_r;
      e.done_cyc    = cyc + 1;
      e.busy_cycles = 0;
    end else begin
      e.q = W'(int'(dd) / int'(dv));
      e.r = W'(int'(dd) % int'(dv));
      last_q = e.q;
      last_r = e.r;
      e.done_cyc    = cyc + 1 + W;
      e.busy_cycles = W;
    end
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    Dividend = 16'($urandom);
    Divisor  = 8'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results still pending after %0d cycles, expected 0", sb.size(), n);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, ".quotient"},  Quotient,  0);
    check({tag, ".remainder"}, Remainder, 0);
    check({tag, ".busy"},      busy,      0);
    check({tag, ".done"},      done,      0);
    check({tag, ".div_error"}, div_error, 0);
  endtask

  initial begin
    logic [2*W-1:0] dd;
    logic [W-1:0]   dv;
    rst = 1'b1; start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    issue(16'd1000, 8'd7, "basic_1000_7");
    drain();
    issue(16'hFEFF, 8'hFF, "max_FEFF_FF");
    drain();
    issue(16'h00FF, 8'h01, "max_00FF_01");
    drain();
    issue(16'h1234, 8'h00, "err_div0");
    drain();
    issue(16'h0100, 8'h01, "err_ovf");
    drain();
    issue(16'h0010, 8'h03, "after_err_16_3");
    drain();

    // Start raised again in the 3rd RUN cycle must be ignored.
    issue(16'd1000, 8'd7, "ignored_start");
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; Dividend = 16'd50; Divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (W + 4) @(negedge clk);

    // Reset in the 4th RUN cycle aborts with no done pulse.
    issue(16'd1000, 8'd7, "aborted");
    repeat (3) @(negedge clk);
    sb.delete();
    last_q = '0; last_r = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("midop_reset");
    repeat (W + 4) @(negedge clk);
    issue(16'd200, 8'd9, "after_reset_200_9");
    drain();

    // Back-to-back: error, then a start on the first IDLE cycle after done.
    issue(16'd65535, 8'd255, "b2b_err");
    while (sb.size() != 0) @(negedge clk);
    issue(16'd255, 8'd16, "b2b_255_16");
    drain();

    for (int i = 0; i < 40; i++) begin
      dv = 8'($urandom);
      dd = 16'($urandom);
      if ((i % 4) != 0 && dv != 0) dd = {8'($urandom_range(int'(dv) - 1, 0)), 8'($urandom)};
      issue(dd, dv, $sformatf("rand%0d_%0d_%0d", i, dd, dv));
      drain();
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end
endmodule
